ysyx_22050550_ifu_fq: RTL and testbench
=======================================

# ysyx_22050550_ifu_fq

Parametrised instruction fetch unit with an internal fetch PC, a single-outstanding cache request channel and a DEPTH-entry fetch queue toward the decode stage. It replaces the pass-through fetch stage between the PC/redirect logic and ID. It decouples cache latency from decode stalls, extracts the 32-bit instruction from an XLEN-wide cache word, and squashes in-flight fetches on redirect (branch, trap, fence.i).

## Interface
Parameters:
- XLEN, 64, PC and cache data width; 32 or 64 only.
- DEPTH, 4, fetch queue entries; power of two, ≥2.
- RESET_PC, 64'h8000_0000, fetch PC after reset; truncated to XLEN.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  flush and restart fetch this cycle.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0.
- cache_req_valid  out  1  fetch request.
- cache_req_ready  in  1  cache accepts the request.
- cache_req_addr  out  XLEN  fetch address; equals the fetch PC register.
- cache_rsp_valid  in  1  response data valid, one cycle per request.
- cache_rsp_data  in  XLEN  fetched word.
- id_valid  out  1  queue head valid.
- id_ready  in  1  ID consumes the head.
- id_pc  out  XLEN  PC of the head instruction.
- id_inst  out  32  head instruction.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT_RSP: request accepted, response pending.
  - WAIT_DROP: request accepted before a redirect; its response must be discarded.
- Credit rule: cache_req_valid = (state==IDLE) && (count < DEPTH) && !redirect_valid && !reset. Counting the in-flight request guarantees a response always has a free slot.
- Request handshake: cache_req_valid && cache_req_ready → latch req_pc = fetch_pc, fetch_pc += 4, go to WAIT_RSP.
- cache_req_addr is stable while the request is pending. A withdrawal happens only on redirect.
- WAIT_RSP with cache_rsp_valid:
  - Push {req_pc, inst} and go to IDLE.
  - inst = cache_rsp_data[63:32] if XLEN==64 and req_pc[2]==1; otherwise cache_rsp_data[31:0].
- WAIT_DROP with cache_rsp_valid → discard the data and go to IDLE.
- Redirect has priority over all other events in the same cycle:
  - Queue is emptied; a pop in that cycle is ignored.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - In WAIT_RSP or WAIT_DROP without cache_rsp_valid, go to WAIT_DROP.
  - In WAIT_RSP or WAIT_DROP with cache_rsp_valid, discard the response and go to IDLE.
  - In IDLE, stay in IDLE; no request is issued in the redirect cycle.
- Queue:
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full, because credit prevents overflow.
  - count stays in 0..DEPTH. Read/write pointers are log2(DEPTH) bits and wrap naturally.
- cache_rsp_valid in IDLE is a protocol error: ignored, and asserted against in simulation.

## Timing
- Reset values: state IDLE, fetch_pc RESET_PC, count 0, pointers 0, id_valid 0. cache_req_valid is 0 during the reset cycle.
- Reset mid-transaction: state returns to IDLE and the queue empties. A response arriving after reset is ignored, as in IDLE.
- Request can issue the cycle after reset deasserts.
- Response at cycle N → id_valid high at N+1 (registered queue). id_pc and id_inst come straight from the head entry.
- Steady state with zero decode stall and response one cycle after accept: one instruction per 2 cycles; single outstanding request by design.
- id_valid/id_pc/id_inst are held while id_ready is low.
- Redirect at cycle N → id_valid low at N+1 → first request at N+1 with cache_req_addr = redirected PC.

## Structure
- Shared package ysyx_22050550_ifu_pkg holds:
  - the FSM state enum (IDLE, WAIT_RSP, WAIT_DROP);
  - the queue entry struct {pc, inst};
  - the default RESET_PC constant.
- Sub-module ysyx_22050550_fetch_fifo: synchronous FIFO with flush, parameters WIDTH and DEPTH, outputs count/full/empty.
- Top level holds the FSM, fetch_pc, req_pc and word select.

## Test plan
- Reset then free-running cache (rsp 1 cycle after accept), id_ready=1:
  - id_pc sequence 0x80000000, 0x80000004, 0x80000008;
  - id_inst = low, high, low words of the respective responses.
- id_ready=0 with DEPTH=4:
  - exactly 4 requests accepted, cache_req_valid then stays 0, count==4;
  - id_ready=1 for one cycle → one pop and exactly one new request.
- Redirect to 0x80001002 in WAIT_RSP, response 2 cycles later:
  - response dropped, queue empty;
  - next cache_req_addr = 0x80001000, first id_pc = 0x80001000.
- Redirect in the same cycle as cache_rsp_valid and an id pop:
  - nothing pushed, queue empty next cycle, state IDLE.
- cache_req_ready low for 5 cycles:
  - cache_req_valid stays high with constant address;
  - fetch_pc advances only on the accepting cycle.
- Reset asserted in WAIT_RSP with 3 queued entries:
  - next cycle id_valid=0, fetch_pc=RESET_PC;
  - a late response is not enqueued.

Source files
------------

// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared types and constants for the decoupled instruction fetch unit.
// Queue entries carry a 64-bit PC so that one packed type serves both XLEN settings.
package ysyx_22050550_ifu_pkg;

    localparam int          MAX_XLEN         = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RSP  = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [31:0]         inst;
    } fq_entry_t;

endpackage

// File: rtl/ysyx_22050550_ifu_fq_if.sv
// Fetch unit boundary: redirect input, cache request/response channel and ID-facing queue head.
interface ysyx_22050550_ifu_fq_if #(
    parameter int XLEN = 64
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            cache_req_valid;
    logic            cache_req_ready;
    logic [XLEN-1:0] cache_req_addr;
    logic            cache_rsp_valid;
    logic [XLEN-1:0] cache_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        output cache_req_valid, cache_req_addr,
        input  cache_req_ready, cache_rsp_valid, cache_rsp_data,
        output id_valid, id_pc, id_inst,
        input  id_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  cache_req_valid, cache_req_addr,
        output cache_req_ready, cache_rsp_valid, cache_rsp_data,
        input  id_valid, id_pc, id_inst,
        output id_ready
    );
endinterface

// File: rtl/ysyx_22050550_fetch_fifo.sv
// Synchronous FIFO with flush. The head entry is read combinationally so that
// a pushed entry is visible to the consumer on the cycle after the push.
module ysyx_22050550_fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // A pop frees the slot in the same cycle, so a push at full is legal alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush && !srst) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ysyx_22050550_ifu_fq.sv
// Instruction fetch unit: fetch PC, one outstanding cache request, and a fetch queue toward ID.
// Redirects flush the queue and squash any in-flight response.
module ysyx_22050550_ifu_fq
    import ysyx_22050550_ifu_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_22050550_ifu_fq_if.master bus
);
    localparam logic [XLEN-1:0] RESET_PC_X = RESET_PC[XLEN-1:0];
    localparam int              CW         = $clog2(DEPTH + 1);

    fetch_state_e     state_reg, state_next;
    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]  req_pc_reg, req_pc_next;
    logic             orphan_reg;
    logic [CW-1:0]    fq_count;
    logic             fq_full;
    logic             fq_empty;
    logic             fq_push;
    logic             fq_pop;
    logic             req_fire;
    logic [31:0]      rsp_inst;
    fq_entry_t        entry_in;
    fq_entry_t        entry_out;

    // Only IDLE has no request in flight, so a free slot now is a slot for its response later.
    assign bus.cache_req_valid = (state_reg == IDLE) && !fq_full && !bus.redirect_valid && !reset;
    assign bus.cache_req_addr  = fetch_pc_reg;
    assign req_fire            = bus.cache_req_valid && bus.cache_req_ready;

    generate
        if (XLEN == 64) begin : g_sel64
            assign rsp_inst = req_pc_reg[2] ? bus.cache_rsp_data[XLEN-1:32] : bus.cache_rsp_data[31:0];
        end else begin : g_sel32
            assign rsp_inst = bus.cache_rsp_data[31:0];
        end
    endgenerate

    assign entry_in.pc   = MAX_XLEN'(req_pc_reg);
    assign entry_in.inst = rsp_inst;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        fq_push       = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_next = bus.redirect_pc & ~XLEN'(3);
            if (state_reg != IDLE) begin
                state_next = bus.cache_rsp_valid ? IDLE : WAIT_DROP;
            end
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        req_pc_next   = fetch_pc_reg;
                        fetch_pc_next = fetch_pc_reg + XLEN'(4);
                        state_next    = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (bus.cache_rsp_valid) begin
                        fq_push    = 1'b1;
                        state_next = IDLE;
                    end
                end
                WAIT_DROP: begin
                    if (bus.cache_rsp_valid) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC_X;
            req_pc_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
        end
    end

    // Remembers that reset abandoned a request, so its late response is not flagged as a protocol error.
    always_ff @(posedge clock) begin
        if (reset) begin
            orphan_reg <= orphan_reg || (state_reg != IDLE);
        end else if (bus.cache_rsp_valid || req_fire) begin
            orphan_reg <= 1'b0;
        end
    end

    a_no_rsp_in_idle: assert property (@(posedge clock) disable iff (reset)
        !((state_reg == IDLE) && bus.cache_rsp_valid && !orphan_reg));

    assign fq_pop = bus.id_valid && bus.id_ready && !bus.redirect_valid;

    ysyx_22050550_fetch_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .flush   (bus.redirect_valid),
        .push    (fq_push),
        .wr_data (entry_in),
        .pop     (fq_pop),
        .rd_data (entry_out),
        .count   (fq_count),
        .full    (fq_full),
        .empty   (fq_empty)
    );

    assign bus.id_valid = !fq_empty;
    assign bus.id_pc    = entry_out.pc[XLEN-1:0];
    assign bus.id_inst  = entry_out.inst;
endmodule

// File: tb/tb_ysyx_22050550_ifu_fq.sv
// Directed bench for the fetch unit: throughput, backpressure, redirect squash, stall and reset.
module tb_ysyx_22050550_ifu_fq;
    import ysyx_22050550_ifu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clock = ~clock;

    ysyx_22050550_ifu_fq_if #(.XLEN(64)) bus ();

    ysyx_22050550_ifu_fq #(
        .XLEN     (64),
        .DEPTH    (4),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rsp_word(input logic [63:0] pc);
        logic [31:0] lo16;
        lo16 = {16'h0, pc[15:0]};
        return {32'hB000_0000 | lo16, 32'hA000_0000 | lo16};
    endfunction

    task automatic clear_inputs();
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.cache_req_ready = 1'b0;
        bus.cache_rsp_valid = 1'b0;
        bus.cache_rsp_data  = '0;
        bus.id_ready        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Expects an IDLE request for pc, accepts it, returns the response one cycle later.
    task automatic fetch_one(input logic [63:0] pc);
        chk("req_valid", 64'(bus.cache_req_valid), 64'd1);
        chk("req_addr", bus.cache_req_addr, pc);
        bus.cache_req_ready = 1'b1;
        tick();
        bus.cache_req_ready = 1'b0;
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_data  = rsp_word(pc);
        tick();
        bus.cache_rsp_valid = 1'b0;
        bus.cache_rsp_data  = '0;
        #1;
        $display("fetch pc=%h data=%h", pc, rsp_word(pc));
    endtask

    logic [31:0] exp_inst [3];

    initial begin
        exp_inst[0] = 32'hA000_0000;
        exp_inst[1] = 32'hB000_0004;
        exp_inst[2] = 32'hA000_0008;
        clear_inputs();

        // Reset state and streaming with no decode stall
        tick();
        #1;
        chk("rst_req_valid", 64'(bus.cache_req_valid), 64'd0);
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        do_reset();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_one(64'h8000_0000 + 64'(4 * i));
            chk("t1_id_valid", 64'(bus.id_valid), 64'd1);
            chk("t1_id_pc", bus.id_pc, 64'h8000_0000 + 64'(4 * i));
            chk("t1_id_inst", 64'(bus.id_inst), 64'(exp_inst[i]));
        end

        // Backpressure: the queue fills and requests stop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_one(64'h8000_0000 + 64'(4 * i));
        end
        chk("t2_full_req_valid", 64'(bus.cache_req_valid), 64'd0);
        chk("t2_count", 64'(dut.fq_count), 64'd4);
        tick();
        tick();
        chk("t2_held_req_valid", 64'(bus.cache_req_valid), 64'd0);
        chk("t2_held_id_pc", bus.id_pc, 64'h8000_0000);
        chk("t2_held_id_inst", 64'(bus.id_inst), 64'hA000_0000);
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        #1;
        chk("t2_pop_count", 64'(dut.fq_count), 64'd3);
        chk("t2_pop_id_pc", bus.id_pc, 64'h8000_0004);
        fetch_one(64'h8000_0010);
        chk("t2_refill_count", 64'(dut.fq_count), 64'd4);
        chk("t2_refill_req_valid", 64'(bus.cache_req_valid), 64'd0);
        tick();
        chk("t2_no_extra_req", 64'(bus.cache_req_valid), 64'd0);

        // Redirect while waiting for a response; the response comes two cycles later
        do_reset();
        bus.id_ready = 1'b1;
        chk("t3_req_addr", bus.cache_req_addr, 64'h8000_0000);
        bus.cache_req_ready = 1'b1;
        tick();
        bus.cache_req_ready = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_pc     = 64'h8000_1002;
        #1;
        chk("t3_redir_req_valid", 64'(bus.cache_req_valid), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
        bus.cache_req_ready = 1'b1;
        #1;
        chk("t3_drop_req_valid", 64'(bus.cache_req_valid), 64'd0);
        tick();
        bus.cache_rsp_valid = 1'b0;
        bus.cache_req_ready = 1'b0;
        #1;
        chk("t3_id_valid", 64'(bus.id_valid), 64'd0);
        chk("t3_count", 64'(dut.fq_count), 64'd0);
        fetch_one(64'h8000_1000);
        chk("t3_id_pc", bus.id_pc, 64'h8000_1000);
        chk("t3_id_inst", 64'(bus.id_inst), 64'hA000_1000);

        // Redirect coinciding with a response and a pop
        do_reset();
        fetch_one(64'h8000_0000);
        chk("t4_req_addr", bus.cache_req_addr, 64'h8000_0004);
        bus.cache_req_ready = 1'b1;
        tick();
        bus.cache_req_ready = 1'b0;
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_data  = rsp_word(64'h8000_0004);
        bus.redirect_valid  = 1'b1;
        bus.redirect_pc     = 64'h8000_2000;
        bus.id_ready        = 1'b1;
        #1;
        chk("t4_pre_id_valid", 64'(bus.id_valid), 64'd1);
        tick();
        clear_inputs();
        #1;
        chk("t4_id_valid", 64'(bus.id_valid), 64'd0);
        chk("t4_count", 64'(dut.fq_count), 64'd0);
        chk("t4_state", 64'(dut.state_reg), 64'(IDLE));
        chk("t4_req_valid", 64'(bus.cache_req_valid), 64'd1);
        chk("t4_req_addr_redir", bus.cache_req_addr, 64'h8000_2000);

        // Cache not ready for five cycles: request held, PC steps once on accept
        for (int i = 0; i < 5; i++) begin
            chk("t5_req_valid", 64'(bus.cache_req_valid), 64'd1);
            chk("t5_req_addr", bus.cache_req_addr, 64'h8000_2000);
            chk("t5_fetch_pc", 64'(dut.fetch_pc_reg), 64'h8000_2000);
            tick();
        end
        bus.cache_req_ready = 1'b1;
        tick();
        bus.cache_req_ready = 1'b0;
        chk("t5_fetch_pc_step", 64'(dut.fetch_pc_reg), 64'h8000_2004);
        chk("t5_wait_req_valid", 64'(bus.cache_req_valid), 64'd0);
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_data  = rsp_word(64'h8000_2000);
        tick();
        bus.cache_rsp_valid = 1'b0;
        #1;
        chk("t5_id_pc", bus.id_pc, 64'h8000_2000);

        // Reset with three queued entries and one request in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_one(64'h8000_0000 + 64'(4 * i));
        end
        bus.cache_req_ready = 1'b1;
        tick();
        bus.cache_req_ready = 1'b0;
        chk("t6_pre_count", 64'(dut.fq_count), 64'd3);
        reset = 1'b1;
        #1;
        chk("t6_rst_req_valid", 64'(bus.cache_req_valid), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_id_valid", 64'(bus.id_valid), 64'd0);
        chk("t6_fetch_pc", 64'(dut.fetch_pc_reg), 64'h8000_0000);
        chk("t6_req_addr", bus.cache_req_addr, 64'h8000_0000);
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_data  = rsp_word(64'h8000_000C);
        tick();
        bus.cache_rsp_valid = 1'b0;
        #1;
        chk("t6_late_id_valid", 64'(bus.id_valid), 64'd0);
        chk("t6_late_count", 64'(dut.fq_count), 64'd0);
        chk("t6_late_state", 64'(dut.state_reg), 64'(IDLE));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
